// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forwarding-select codes and the register-match helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_BUSY   = 2'd1,
        EXC_FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Register $0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// Combinational forwarding-select and load-use / branch stall detection
// for the pipeline hazard controller.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs_d,
    input  logic [4:0] i_rt_d,
    input  logic [4:0] i_rs_e,
    input  logic [4:0] i_rt_e,
    input  logic [4:0] i_wr_e,
    input  logic [4:0] i_wr_m,
    input  logic [4:0] i_wr_w,
    input  logic       i_regwrite_e,
    input  logic       i_regwrite_m,
    input  logic       i_regwrite_w,
    input  logic       i_memtoreg_e,
    input  logic       i_memtoreg_m,
    input  logic       i_branch_d,
    input  logic       i_jr_d,
    output logic [1:0] o_fwd_ae,
    output logic [1:0] o_fwd_be,
    output logic       o_fwd_ad,
    output logic       o_fwd_bd,
    output logic       o_lwstall,
    output logic       o_brstall
);

    logic w_dep_e;
    logic w_dep_m;

    always_comb begin
        o_fwd_ae = FWD_RF;
        if (i_regwrite_m && reg_match(i_rs_e, i_wr_m))
            o_fwd_ae = FWD_M;
        else if (i_regwrite_w && reg_match(i_rs_e, i_wr_w))
            o_fwd_ae = FWD_W;

        o_fwd_be = FWD_RF;
        if (i_regwrite_m && reg_match(i_rt_e, i_wr_m))
            o_fwd_be = FWD_M;
        else if (i_regwrite_w && reg_match(i_rt_e, i_wr_w))
            o_fwd_be = FWD_W;
    end

    assign o_fwd_ad = i_regwrite_m && reg_match(i_rs_d, i_wr_m);
    assign o_fwd_bd = i_regwrite_m && reg_match(i_rt_d, i_wr_m);

    assign o_lwstall = i_memtoreg_e && (reg_match(i_rt_e, i_rs_d) || reg_match(i_rt_e, i_rt_d));

    assign w_dep_e   = i_regwrite_e && (reg_match(i_rs_d, i_wr_e) || reg_match(i_rt_d, i_wr_e));
    assign w_dep_m   = i_memtoreg_m && (reg_match(i_rs_d, i_wr_m) || reg_match(i_rt_d, i_wr_m));
    assign o_brstall = (i_branch_d || i_jr_d) && (w_dep_e || w_dep_m);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with mult/div
// sequencing and exception flush. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT    = 32,
    parameter int unsigned EXC_FLUSH_CYC = 2,
    parameter int unsigned CNT_W         = 6
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] WriteReg_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_E,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       MemtoReg_E,
    input  logic       MemtoReg_M,
    input  logic       Branch_D,
    input  logic       Jr_D,
    input  logic       PCSrc_D,
    input  logic       J_D,
    input  logic       hilo_use_D,
    input  logic       muldiv_start_E,
    input  logic       exc_M,
    output logic       EN_F,
    output logic       EN_D,
    output logic       EN_E,
    output logic       CLR_D,
    output logic       CLR_E,
    output logic       CLR_M,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       muldiv_busy,
    output logic       muldiv_abort,
    output logic       pc_exc_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] EXC_LOAD = CNT_W'(EXC_FLUSH_CYC - 1);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       w_fwd_ae, w_fwd_be;
    logic             w_fwd_ad, w_fwd_bd;
    logic             w_lwstall, w_brstall, w_mdstall, w_stall, w_busy, w_flush;

    hazard_fwd_unit u_fwd (
        .i_rs_d       (Rs_D),
        .i_rt_d       (Rt_D),
        .i_rs_e       (Rs_E),
        .i_rt_e       (Rt_E),
        .i_wr_e       (WriteReg_E),
        .i_wr_m       (WriteReg_M),
        .i_wr_w       (WriteReg_W),
        .i_regwrite_e (RegWrite_E),
        .i_regwrite_m (RegWrite_M),
        .i_regwrite_w (RegWrite_W),
        .i_memtoreg_e (MemtoReg_E),
        .i_memtoreg_m (MemtoReg_M),
        .i_branch_d   (Branch_D),
        .i_jr_d       (Jr_D),
        .o_fwd_ae     (w_fwd_ae),
        .o_fwd_be     (w_fwd_be),
        .o_fwd_ad     (w_fwd_ad),
        .o_fwd_bd     (w_fwd_bd),
        .o_lwstall    (w_lwstall),
        .o_brstall    (w_brstall)
    );

    assign w_busy    = (r_state == MD_BUSY);
    assign w_mdstall = w_busy && hilo_use_D;
    assign w_stall   = w_lwstall || w_brstall || w_mdstall;
    assign w_flush   = exc_M || (r_state == EXC_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        EN_F         = !w_stall;
        EN_D         = !w_stall;
        EN_E         = !w_stall;
        CLR_D        = (PCSrc_D || J_D) && !w_stall;
        CLR_E        = w_stall;
        CLR_M        = 1'b0;
        pc_exc_sel   = 1'b0;
        muldiv_busy  = w_busy;
        muldiv_abort = 1'b0;
        ForwardAE    = w_fwd_ae;
        ForwardBE    = w_fwd_be;
        ForwardAD    = w_fwd_ad;
        ForwardBD    = w_fwd_bd;

        // Flush overrides every stall; EN_E must be low since the D/E register favours EN over CLR.
        if (w_flush) begin
            EN_F       = 1'b1;
            EN_D       = 1'b1;
            EN_E       = 1'b0;
            CLR_D      = 1'b1;
            CLR_E      = 1'b1;
            CLR_M      = 1'b1;
            pc_exc_sel = exc_M;
        end

        case (r_state)
            RUN: begin
                if (exc_M) begin
                    w_state_nxt = EXC_FLUSH;
                    w_cnt_nxt   = EXC_LOAD;
                end else if (muldiv_start_E && !w_stall) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (exc_M) begin
                    w_state_nxt  = EXC_FLUSH;
                    w_cnt_nxt    = EXC_LOAD;
                    muldiv_abort = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            EXC_FLUSH: begin
                if (exc_M) begin
                    w_cnt_nxt = EXC_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        if (rst) begin
            EN_F         = 1'b0;
            EN_D         = 1'b0;
            EN_E         = 1'b0;
            CLR_D        = 1'b1;
            CLR_E        = 1'b1;
            CLR_M        = 1'b1;
            ForwardAE    = FWD_RF;
            ForwardBE    = FWD_RF;
            ForwardAD    = 1'b0;
            ForwardBD    = 1'b0;
            muldiv_busy  = 1'b0;
            muldiv_abort = 1'b0;
            pc_exc_sel   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !w_flush)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (exc_M)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized stimulus against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

    localparam int LAT  = 4;
    localparam int FCYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic       Branch_D, Jr_D, PCSrc_D, J_D, hilo_use_D, muldiv_start_E, exc_M;
    logic       EN_F, EN_D, EN_E, CLR_D, CLR_E, CLR_M;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, muldiv_busy, muldiv_abort, pc_exc_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MULDIV_LAT    (LAT),
        .EXC_FLUSH_CYC (FCYC),
        .CNT_W         (6)
    ) dut (
        .clk(clk), .rst(rst),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
        .Branch_D(Branch_D), .Jr_D(Jr_D), .PCSrc_D(PCSrc_D), .J_D(J_D),
        .hilo_use_D(hilo_use_D), .muldiv_start_E(muldiv_start_E), .exc_M(exc_M),
        .EN_F(EN_F), .EN_D(EN_D), .EN_E(EN_E),
        .CLR_D(CLR_D), .CLR_E(CLR_E), .CLR_M(CLR_M),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .muldiv_busy(muldiv_busy), .muldiv_abort(muldiv_abort), .pc_exc_sel(pc_exc_sel)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int busy_left  = 0;   // remaining mult/div busy cycles
    int flush_left = 0;   // remaining post-exception flush cycles

    function automatic logic dep(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (RegWrite_M && dep(src, WriteReg_M)) return 2'b10;
        if (RegWrite_W && dep(src, WriteReg_W)) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin : model
        logic [1:0] e_fae, e_fbe;
        logic e_fad, e_fbd, e_enf, e_end, e_ene, e_clrd, e_clre, e_clrm;
        logic e_busy, e_abort, e_pc, stall, flushing;
        stall = (MemtoReg_E && (dep(Rt_E, Rs_D) || dep(Rt_E, Rt_D)))
             || ((Branch_D || Jr_D) &&
                 ((RegWrite_E && (dep(Rs_D, WriteReg_E) || dep(Rt_D, WriteReg_E))) ||
                  (MemtoReg_M && (dep(Rs_D, WriteReg_M) || dep(Rt_D, WriteReg_M)))))
             || (busy_left > 0 && flush_left == 0 && hilo_use_D);
        flushing = exc_M || flush_left > 0;
        if (rst) begin
            {e_fae, e_fbe, e_fad, e_fbd} = '0;
            {e_enf, e_end, e_ene} = 3'b000;
            {e_clrd, e_clre, e_clrm} = 3'b111;
            {e_busy, e_abort, e_pc} = 3'b000;
        end else begin
            e_fae = fwd_e(Rs_E);
            e_fbe = fwd_e(Rt_E);
            e_fad = RegWrite_M && dep(Rs_D, WriteReg_M);
            e_fbd = RegWrite_M && dep(Rt_D, WriteReg_M);
            e_busy = busy_left > 0 && flush_left == 0;
            if (flushing) begin
                {e_enf, e_end, e_ene} = 3'b110;
                {e_clrd, e_clre, e_clrm} = 3'b111;
                e_pc = exc_M;
                e_abort = exc_M && e_busy;
            end else begin
                e_enf = !stall; e_end = !stall; e_ene = !stall;
                e_clrd = (PCSrc_D || J_D) && !stall;
                e_clre = stall; e_clrm = 1'b0;
                e_pc = 1'b0; e_abort = 1'b0;
            end
        end
        chk("EN_F", EN_F, e_enf);   chk("EN_D", EN_D, e_end);   chk("EN_E", EN_E, e_ene);
        chk("CLR_D", CLR_D, e_clrd); chk("CLR_E", CLR_E, e_clre); chk("CLR_M", CLR_M, e_clrm);
        chk("ForwardAE", ForwardAE, e_fae); chk("ForwardBE", ForwardBE, e_fbe);
        chk("ForwardAD", ForwardAD, e_fad); chk("ForwardBD", ForwardBD, e_fbd);
        chk("muldiv_busy", muldiv_busy, e_busy);
        chk("muldiv_abort", muldiv_abort, e_abort);
        chk("pc_exc_sel", pc_exc_sel, e_pc);
        chk("EN_E_vs_CLR_E", EN_E && CLR_E, 1'b0);
        // advance model to the next cycle (inputs are stable until after the next rising edge)
        if (rst) begin
            busy_left = 0; flush_left = 0;
        end else if (exc_M) begin
            flush_left = FCYC; busy_left = 0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (muldiv_start_E && !stall) begin
            busy_left = LAT;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        {Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W} = '0;
        {RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M} = '0;
        {Branch_D, Jr_D, PCSrc_D, J_D, hilo_use_D, muldiv_start_E, exc_M} = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic rand_inputs();
        Rs_D = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3));
        Rs_E = 5'($urandom_range(0, 3)); Rt_E = 5'($urandom_range(0, 3));
        WriteReg_E = 5'($urandom_range(0, 3)); WriteReg_M = 5'($urandom_range(0, 3));
        WriteReg_W = 5'($urandom_range(0, 3));
        RegWrite_E = $urandom_range(0, 1) == 1; RegWrite_M = $urandom_range(0, 1) == 1;
        RegWrite_W = $urandom_range(0, 1) == 1;
        MemtoReg_E = $urandom_range(0, 3) == 0; MemtoReg_M = $urandom_range(0, 3) == 0;
        Branch_D = $urandom_range(0, 3) == 0; Jr_D = $urandom_range(0, 7) == 0;
        PCSrc_D = $urandom_range(0, 3) == 0; J_D = $urandom_range(0, 7) == 0;
        hilo_use_D = $urandom_range(0, 1) == 1;
        muldiv_start_E = $urandom_range(0, 3) == 0;
        exc_M = $urandom_range(0, 19) == 0;
        rst = $urandom_range(0, 99) == 0;
    endtask

    task automatic start_md();
        tick(); idle(); muldiv_start_E = 1'b1;
        settle(); chk("md_start_not_busy", muldiv_busy, 1'b0);
        tick(); muldiv_start_E = 1'b0;
    endtask

    initial begin
        idle(); rst = 1'b1;
        tick(); tick();
        settle();
        chk("rst_EN_F", EN_F, 1'b0); chk("rst_CLR_M", CLR_M, 1'b1); chk("rst_busy", muldiv_busy, 1'b0);
        tick(); rst = 1'b0;

        // forwarding priority and register 0
        RegWrite_M = 1; WriteReg_M = 5; Rs_E = 5; RegWrite_W = 1; WriteReg_W = 5;
        settle(); chk("fwd_m_prio", ForwardAE, 2'b10);
        tick(); WriteReg_M = 0;
        settle(); chk("fwd_w", ForwardAE, 2'b01);
        tick(); Rs_E = 0;
        settle(); chk("fwd_r0", ForwardAE, 2'b00);

        // load-use bubble for one cycle
        tick(); idle(); MemtoReg_E = 1; Rt_E = 8; Rs_D = 8;
        settle(); chk("lw_EN_F", EN_F, 1'b0); chk("lw_EN_E", EN_E, 1'b0); chk("lw_CLR_E", CLR_E, 1'b1);
        tick(); MemtoReg_E = 0;
        settle(); chk("lw_rel_EN_F", EN_F, 1'b1); chk("lw_rel_EN_E", EN_E, 1'b1);

        // mult/div busy window with HI/LO consumer waiting in D
        start_md(); hilo_use_D = 1;
        for (int i = 0; i < LAT; i++) begin
            settle(); chk("md_busy", muldiv_busy, 1'b1); chk("md_stall", EN_F, 1'b0);
            tick();
        end
        settle(); chk("md_done_busy", muldiv_busy, 1'b0); chk("md_done_EN_F", EN_F, 1'b1);

        // exception on the 2nd busy cycle
        start_md();
        settle(); chk("exc_b1_busy", muldiv_busy, 1'b1);
        tick(); exc_M = 1;
        settle(); chk("exc_abort", muldiv_abort, 1'b1); chk("exc_pc", pc_exc_sel, 1'b1);
        chk("exc_CLR_M", CLR_M, 1'b1); chk("exc_EN_E", EN_E, 1'b0);
        tick(); exc_M = 0;
        for (int i = 0; i < FCYC; i++) begin
            settle(); chk("fl_abort", muldiv_abort, 1'b0); chk("fl_pc", pc_exc_sel, 1'b0);
            chk("fl_CLR_D", CLR_D, 1'b1); chk("fl_CLR_M", CLR_M, 1'b1); chk("fl_busy", muldiv_busy, 1'b0);
            tick();
        end
        settle(); chk("post_fl_CLR_M", CLR_M, 1'b0); chk("post_fl_EN_E", EN_E, 1'b1);
        chk("post_fl_busy", muldiv_busy, 1'b0);

        // taken branch flushes D; branch with pending ALU result stalls instead
        tick(); idle(); PCSrc_D = 1;
        settle(); chk("br_CLR_D", CLR_D, 1'b1); chk("br_EN_E", EN_E, 1'b1);
        tick(); Branch_D = 1; RegWrite_E = 1; WriteReg_E = 3; Rs_D = 3;
        settle(); chk("brst_EN_F", EN_F, 1'b0); chk("brst_CLR_D", CLR_D, 1'b0); chk("brst_CLR_E", CLR_E, 1'b1);
        tick(); RegWrite_E = 0;
        settle(); chk("br_res_CLR_D", CLR_D, 1'b1); chk("br_res_EN_F", EN_F, 1'b1);

        // reset while busy with cnt=2
        start_md();
        settle(); chk("rb_b1", muldiv_busy, 1'b1);
        tick(); rst = 1;
        settle(); chk("rb_busy", muldiv_busy, 1'b0); chk("rb_abort", muldiv_abort, 1'b0);
        tick(); rst = 0;
        settle(); chk("rb_after_busy", muldiv_busy, 1'b0); chk("rb_after_abort", muldiv_abort, 1'b0);
        chk("rb_after_EN_F", EN_F, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            tick(); rand_inputs();
        end
        tick(); idle(); rst = 0;
        settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
